// File: rtl/xtsc_irq_ctrl.sv
// Interrupt controller between TIE export-state sources and the Xtensa BInterruptXX input.
// Sources latch as level or edge, are masked, and raise one line through an assert/holdoff FSM.
module xtsc_irq_ctrl #(
    parameter int NUM_SRC        = 32,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        BReset_n,
    input  logic [31:0] EXPSTATE,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        BInterruptXX
);

    localparam logic [31:0] SRC_MASK     = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                           : ((32'd1 << NUM_SRC) - 32'd1);
    localparam bit          HAS_HOLDOFF  = (HOLDOFF_CYCLES > 0);
    localparam logic [7:0]  HOLDOFF_LOAD = HAS_HOLDOFF ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_TYPE    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic [31:0] pending_r, mask_r, type_r, src_d_r, rdata_r;
    logic [31:0] src_s, rise_s, w1c_s, pending_nxt_s, status_s, rdata_nxt_s;
    logic        wr_mask_s, wr_type_s;
    logic        active_s, bint_r;
    logic [7:0]  cnt_r, cnt_nxt_s;
    state_t      state_r, state_nxt_s;

    assign active_s     = |(pending_r & mask_r);
    assign status_s     = {15'd0, active_s, cnt_r, 6'd0, state_r};
    assign reg_rdata    = rdata_r;
    assign BInterruptXX = bint_r;

    // Per-source pending update; an edge set in the same cycle as a W1C wins
    always_comb begin
        src_s     = EXPSTATE & SRC_MASK;
        rise_s    = src_s & ~src_d_r;
        wr_mask_s = reg_wr && (reg_addr == ADDR_MASK);
        wr_type_s = reg_wr && (reg_addr == ADDR_TYPE);
        w1c_s     = 32'd0;
        if (reg_wr && (reg_addr == ADDR_PENDING)) begin
            w1c_s = reg_wdata & SRC_MASK;
        end else begin
            w1c_s = 32'd0;
        end
        pending_nxt_s = (~type_r & src_s) | (type_r & (rise_s | (pending_r & ~w1c_s)));
    end

    // Next-state and holdoff counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (active_s) begin
                    state_nxt_s = ST_ASSERT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (!active_s) begin
                    if (HAS_HOLDOFF) begin
                        state_nxt_s = ST_HOLDOFF;
                        cnt_nxt_s   = HOLDOFF_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = 8'd0;
                    end
                end else begin
                    state_nxt_s = ST_ASSERT;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_r == 8'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Read mux; samples state before any same-cycle write and otherwise holds
    always_comb begin
        rdata_nxt_s = rdata_r;
        if (reg_rd) begin
            case (reg_addr)
                ADDR_PENDING: rdata_nxt_s = pending_r;
                ADDR_MASK:    rdata_nxt_s = mask_r;
                ADDR_TYPE:    rdata_nxt_s = type_r;
                ADDR_STATUS:  rdata_nxt_s = status_s;
                default:      rdata_nxt_s = 32'd0;
            endcase
        end else begin
            rdata_nxt_s = rdata_r;
        end
    end

    // Source sampling, pending latch and configuration registers
    always_ff @(posedge CLK or negedge BReset_n) begin
        if (!BReset_n) begin
            src_d_r   <= 32'd0;
            pending_r <= 32'd0;
            mask_r    <= 32'd0;
            type_r    <= 32'd0;
        end else begin
            src_d_r   <= src_s;
            pending_r <= pending_nxt_s;
            if (wr_mask_s) begin
                mask_r <= reg_wdata & SRC_MASK;
            end
            if (wr_type_s) begin
                type_r <= reg_wdata & SRC_MASK;
            end
        end
    end

    // FSM state, holdoff counter and registered interrupt line
    always_ff @(posedge CLK or negedge BReset_n) begin
        if (!BReset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            bint_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            bint_r  <= (state_nxt_s == ST_ASSERT);
        end
    end

    // Read data register
    always_ff @(posedge CLK or negedge BReset_n) begin
        if (!BReset_n) begin
            rdata_r <= 32'd0;
        end else begin
            rdata_r <= rdata_nxt_s;
        end
    end

endmodule
